// File: rtl/tap_window_serializer.sv
// tap_window_serializer
//   Accepts a full tap window (NUM_REGS samples) in one valid/ready handshake.
//   Replays the window one sample per cycle, tap 0 first.
//   A one-window pending buffer lets the next window be accepted while the
//   current one drains, so consecutive windows stream with no bubble.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   pDataIn           parallel tap window, element 0 = newest sample
//   inValid/inReady   input handshake (inReady = !pendValid && !rst)
//   sDataOut          current serial sample, active[idx]
//   outValid/outReady output handshake
//   outIdx            tap index of sDataOut
//   outFirst/outLast  first / last beat of a window
//   busy              active or pending window held
//   winCount          completed windows, 16-bit wrapping

`ifndef NUM_REGS
`define NUM_REGS 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

// One tap's storage: the active sample plus its pending copy.
module tap_window_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_act_in,
  input  logic                  ld_act_pend,
  input  logic                  ld_pend,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] act
);
  logic [DATA_WIDTH-1:0] pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      act  <= '0;
      pend <= '0;
    end else begin
      if (ld_act_in)        act <= din;
      else if (ld_act_pend) act <= pend;
      if (ld_pend)          pend <= din;
    end
  end
endmodule

module tap_window_serializer #(
  parameter int NUM_REGS   = `NUM_REGS,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [0:NUM_REGS-1][DATA_WIDTH-1:0]  pDataIn,
  input  logic                                 inValid,
  output logic                                 inReady,
  output logic [DATA_WIDTH-1:0]                sDataOut,
  output logic                                 outValid,
  input  logic                                 outReady,
  output logic [IDX_W-1:0]                     outIdx,
  output logic                                 outFirst,
  output logic                                 outLast,
  output logic                                 busy,
  output logic [15:0]                          winCount
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic                  activeValid, pendValid;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] act [NUM_REGS];
  logic                  push, pop, done;
  logic                  ld_act_in, ld_act_pend, ld_pend;

  assign inReady = !pendValid && !rst;
  assign push    = inValid && inReady;
  assign pop     = activeValid && outReady;
  assign done    = pop && (idx == LAST_IDX);

  // Fresh window goes straight to active when the slot is empty or frees up
  // this cycle with nothing pending; otherwise it parks in pend. A push can
  // never coincide with done && pendValid because inReady is low then.
  assign ld_act_in   = push && (!activeValid || (done && !pendValid));
  assign ld_act_pend = done && pendValid;
  assign ld_pend     = push && activeValid && !done;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_lane
    tap_window_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .ld_act_in  (ld_act_in),
      .ld_act_pend(ld_act_pend),
      .ld_pend    (ld_pend),
      .din        (pDataIn[g]),
      .act        (act[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      activeValid <= 1'b0;
      pendValid   <= 1'b0;
      idx         <= '0;
      winCount    <= '0;
    end else if (!activeValid) begin
      if (push) begin
        activeValid <= 1'b1;
        idx         <= '0;
      end
    end else if (!done) begin
      if (pop)  idx       <= idx + 1'b1;
      if (push) pendValid <= 1'b1;
    end else begin
      winCount <= winCount + 16'd1;
      idx      <= '0;
      if (pendValid)  pendValid   <= 1'b0;
      else if (!push) activeValid <= 1'b0;
    end
  end

  assign sDataOut = act[idx];
  assign outValid = activeValid;
  assign outIdx   = idx;
  assign outFirst = activeValid && (idx == '0);
  assign outLast  = activeValid && (idx == LAST_IDX);
  assign busy     = activeValid || pendValid;
endmodule

// File: tb/tb_tap_window_serializer.sv
module tb_tap_window_serializer;
  localparam int N = 4;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [0:N-1][W-1:0] pDataIn = '0;
  logic                inValid = 1'b0;
  logic                outReady = 1'b1;
  logic                inReady, outValid, outFirst, outLast, busy;
  logic [W-1:0]        sDataOut;
  logic [1:0]          outIdx;
  logic [15:0]         winCount;

  tap_window_serializer #(.NUM_REGS(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .pDataIn(pDataIn), .inValid(inValid),
    .inReady(inReady), .sDataOut(sDataOut), .outValid(outValid),
    .outReady(outReady), .outIdx(outIdx), .outFirst(outFirst),
    .outLast(outLast), .busy(busy), .winCount(winCount)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; int i; } beat_t;
  beat_t sb[$];
  int checks = 0;
  int fails  = 0;
  int exp_win = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a window and queue its expected beats in order.
  task automatic drive(input logic [0:N-1][W-1:0] w);
    pDataIn = w;
    inValid = 1'b1;
    for (int i = 0; i < N; i++) sb.push_back('{w[i], i});
  endtask

  // Scoreboard monitor: every accepted beat is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_beat: got data 0x%0h idx %0d expected none", sDataOut, outIdx);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_data",  32'(sDataOut), 32'(e.d));
        chk("beat_idx",   32'(outIdx),   32'(e.i));
        chk("beat_first", 32'(outFirst), 32'(e.i == 0));
        chk("beat_last",  32'(outLast),  32'(e.i == N-1));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [0:N-1][W-1:0] wD;
  int  idxs [7] = '{0, 1, 2, 2, 2, 2, 3};
  bit  rdys [7] = '{1, 1, 0, 0, 0, 1, 1};

  initial begin
    // Reset
    repeat (2) step();
    @(negedge clk);
    chk("inReady_in_rst", 32'(inReady), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outValid", 32'(outValid), 0);
    chk("rst_outFirst", 32'(outFirst), 0);
    chk("rst_outLast",  32'(outLast),  0);
    chk("rst_busy",     32'(busy),     0);
    chk("rst_sDataOut", 32'(sDataOut), 0);
    chk("rst_outIdx",   32'(outIdx),   0);
    chk("rst_winCount", 32'(winCount), 0);
    chk("rst_inReady",  32'(inReady),  1);
    step();

    // Single window
    drive({16'h0011, 16'h0022, 16'h0033, 16'h0044});
    @(negedge clk);
    chk("t1_inReady", 32'(inReady), 1);
    step();
    inValid = 1'b0;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      chk("t1_outValid", 32'(outValid), 1);
      chk("t1_outFirst", 32'(outFirst), 32'(c == 0));
      chk("t1_outLast",  32'(outLast),  32'(c == N-1));
      step();
    end
    @(negedge clk);
    exp_win++;
    chk("t1_idle_outValid", 32'(outValid), 0);
    chk("t1_idle_busy",     32'(busy),     0);
    chk("t1_winCount",      32'(winCount), 32'(exp_win));
    step();

    // Back-to-back: B lands in pend one cycle after A
    drive({16'hA000, 16'hA001, 16'hA002, 16'hA003});
    @(negedge clk);
    step();
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) drive({16'hB000, 16'hB001, 16'hB002, 16'hB003});
      if (c == 2) inValid = 1'b0;
      @(negedge clk);
      chk("t2_contig_valid", 32'(outValid), 1);
      if (c >= 2 && c <= 4) chk("t2_inReady_full", 32'(inReady), 0);
      if (c == 5) chk("t2_inReady_back", 32'(inReady), 1);
      step();
    end
    @(negedge clk);
    exp_win += 2;
    chk("t2_idle_outValid", 32'(outValid), 0);
    chk("t2_winCount",      32'(winCount), 32'(exp_win));
    step();

    // Direct reload: C pushed in the cycle the last A beat pops
    drive({16'h1A00, 16'h1A01, 16'h1A02, 16'h1A03});
    @(negedge clk);
    step();
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) inValid = 1'b0;
      if (c == 4) drive({16'hC000, 16'hC001, 16'hC002, 16'hC003});
      if (c == 5) inValid = 1'b0;
      @(negedge clk);
      chk("t3_no_bubble", 32'(outValid), 1);
      if (c == 4) begin
        chk("t3_last_idx", 32'(outIdx),  3);
        chk("t3_inReady",  32'(inReady), 1);
      end
      step();
    end
    @(negedge clk);
    exp_win += 2;
    chk("t3_idle_outValid", 32'(outValid), 0);
    chk("t3_winCount",      32'(winCount), 32'(exp_win));
    step();

    // Backpressure: 3 stalled cycles at idx 2
    wD = {16'hD100, 16'hD201, 16'hD302, 16'hD403};
    drive(wD);
    @(negedge clk);
    step();
    inValid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      outReady = rdys[c];
      @(negedge clk);
      chk("t4_outValid", 32'(outValid), 1);
      chk("t4_outIdx",   32'(outIdx),   32'(idxs[c]));
      chk("t4_sDataOut", 32'(sDataOut), 32'(wD[idxs[c]]));
      chk("t4_outLast",  32'(outLast),  32'(idxs[c] == N-1));
      step();
    end
    outReady = 1'b1;
    @(negedge clk);
    exp_win++;
    chk("t4_idle_outValid", 32'(outValid), 0);
    chk("t4_winCount",      32'(winCount), 32'(exp_win));
    step();

    // Full buffer: G held on inValid while E active and F pending
    drive({16'hE000, 16'hE001, 16'hE002, 16'hE003});
    @(negedge clk);
    step();
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) drive({16'hF000, 16'hF001, 16'hF002, 16'hF003});
      if (c == 2) drive({16'h6000, 16'h6001, 16'h6002, 16'h6003});
      if (c == 6) inValid = 1'b0;
      @(negedge clk);
      chk("t5_outValid", 32'(outValid), 1);
      if (c >= 2 && c <= 4) chk("t5_inReady_full", 32'(inReady), 0);
      if (c == 5)           chk("t5_inReady_free", 32'(inReady), 1);
      if (c >= 6 && c <= 8) chk("t5_inReady_full2", 32'(inReady), 0);
      if (c == 9)           chk("t5_inReady_free2", 32'(inReady), 1);
      step();
    end
    @(negedge clk);
    exp_win += 3;
    chk("t5_idle_outValid", 32'(outValid), 0);
    chk("t5_winCount",      32'(winCount), 32'(exp_win));
    chk("sb_drained",       32'(sb.size()), 0);
    step();

    // Reset mid-window with pend full
    drive({16'h7000, 16'h7001, 16'h7002, 16'h7003});
    @(negedge clk);
    step();
    drive({16'h8000, 16'h8001, 16'h8002, 16'h8003});
    @(negedge clk);
    step();
    inValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_pre_idx",     32'(outIdx),  1);
    chk("t6_pre_busy",    32'(busy),    1);
    chk("t6_inReady_rst", 32'(inReady), 0);
    step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t6_outValid", 32'(outValid), 0);
    chk("t6_busy",     32'(busy),     0);
    chk("t6_winCount", 32'(winCount), 0);
    chk("t6_inReady",  32'(inReady),  1);
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_no_beats", 32'(outValid), 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/tap_window_serializer.md
# tap_window_serializer

Parallel-in, serial-out converter for the FIR datapath. Accepts a full tap window (NUM_REGS samples) in one valid/ready handshake and replays it one sample per cycle, tap 0 first, to a downstream serial consumer such as a single time-multiplexed MAC. A one-window pending buffer lets the next window be accepted while the current one drains, so consecutive windows stream with no bubble.

## Interface
- NUM_REGS, default `NUM_REGS (constants.svh), taps per window, >= 1
- DATA_WIDTH, default `DATA_WIDTH (constants.svh), bits per sample
- IDX_W, derived as max(1, $clog2(NUM_REGS)), not overridable

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pDataIn  in  DATA_WIDTH x [0:NUM_REGS-1]  parallel tap window; element 0 is the newest sample
- inValid  in  1  pDataIn valid
- inReady  out  1  window can be accepted; combinational, equals !pendValid && !rst
- sDataOut  out  DATA_WIDTH  current serial sample, active[idx]
- outValid  out  1  sDataOut valid
- outReady  in  1  consumer accepts sDataOut
- outIdx  out  IDX_W  tap index of sDataOut
- outFirst  out  1  outIdx == 0 and outValid
- outLast  out  1  outIdx == NUM_REGS-1 and outValid
- busy  out  1  activeValid || pendValid
- winCount  out  16  completed windows, wraps 0xFFFF -> 0

## Operation
- State: active[0:NUM_REGS-1], activeValid (drives outValid), pend[0:NUM_REGS-1], pendValid, idx, winCount.
- Events: push = inValid && inReady; pop = outValid && outReady; done = pop && idx == NUM_REGS-1.
- activeValid = 0: push loads active <= pDataIn, activeValid <= 1, idx <= 0.
- activeValid = 1 and not done:
  - pop: idx <= idx + 1.
  - push: pend <= pDataIn, pendValid <= 1.
- done, winCount increments, then:
  - pendValid = 1: active <= pend, pendValid <= 0, idx <= 0, activeValid stays 1. No push is possible this cycle because inReady = 0.
  - pendValid = 0 and push: active <= pDataIn, idx <= 0, activeValid stays 1. The window is loaded directly with zero bubble.
  - otherwise: activeValid <= 0, idx <= 0.
- Stall: when outValid = 1 and outReady = 0, sDataOut, outIdx, outFirst and outLast hold stable. inValid is ignored while inReady = 0. The producer must hold pDataIn until its handshake.
- NUM_REGS = 1: every beat is both first and last, and each pop is a done.
- Sample order is tap 0 up to tap NUM_REGS-1. Samples pass unmodified with no width change.

## Timing
- Reset: while rst = 1 at a clock edge, activeValid, pendValid, idx and winCount are cleared to 0, and active and pend are cleared to all zero. After reset, outValid = 0, outFirst = 0, outLast = 0, busy = 0, sDataOut = 0 and outIdx = 0. inReady is 0 during reset and 1 in the first cycle after reset.
- Reset mid-window aborts both the active and pending windows with no further output beats.
- Latency: a push at edge T into an empty block gives outValid = 1 and outIdx = 0 after edge T, so the beat is visible in cycle T+1.
- Throughput: with outReady held at 1, one window takes NUM_REGS cycles. Back-to-back windows produce a continuous outValid.
- sDataOut is a combinational mux of registered state. outValid, outIdx, outFirst and outLast are registered or derived only from registers. No input-to-output combinational path exists except inReady from rst.

## Test plan
Bench setup: NUM_REGS = 4, DATA_WIDTH = 16.
- Single window: push {0x0011, 0x0022, 0x0033, 0x0044} with outReady = 1. Require outValid for cycles 1-4, sDataOut 0x0011, 0x0022, 0x0033, 0x0044, outIdx 0-3, outFirst in cycle 1 only, outLast in cycle 4 only, then outValid = 0, busy = 0 and winCount = 1.
- Back-to-back: push window A, then window B one cycle later (goes to pend, inReady drops to 0). Require 8 contiguous valid beats A0..A3, B0..B3, inReady returning to 1 the cycle after A3 pops, and winCount = 2.
- Direct reload: push window C exactly in the cycle A3 pops, with pend empty. Require C0 to appear in the next cycle with no bubble.
- Backpressure: drop outReady for 3 cycles at idx = 2. Require sDataOut, outIdx and outLast to stay constant, with no beat skipped or duplicated.
- Full buffer: with active and pend both occupied, hold inValid = 1 with a new window. Require inReady = 0 and the window not accepted until the active window completes.
- Reset: assert rst at idx = 1 with pend full. In the next cycle require outValid = 0, busy = 0, winCount = 0 and inReady = 1 after rst deasserts.
